// File: rtl/seq_det_pkg.sv
// =============================================================================
// Module   : seq_det_pkg
// Brief    : Shared state encoding, default sizes and width helper for the
//            programmable serial pattern detector.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CONFIGURED = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    localparam int c_def_max_len = 8;
    localparam int c_def_cnt_w   = 8;

    // Width needed to hold a pattern length in the range 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_core.sv
// =============================================================================
// Module   : seq_match_core
// Brief    : History shift register, fill counter and masked pattern compare.
//            SEQ_DETECT_NONOVERLAP_EN restarts the fill count after every hit.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   w_fill_next;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_fill_ok;

    assign w_hist_next = {r_hist[MAX_LEN-2:0], bit_in};

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign w_mask[gi] = (len > LEN_W'(gi));
        end
    endgenerate

    // The incoming bit completes the window once fill reaches len-1.
    assign w_fill_inc  = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
    assign w_fill_ok   = (w_fill_inc >= {1'b0, len});
    assign w_fill_next = (r_fill < len) ? (r_fill + LEN_W'(1)) : r_fill;

    assign hit = shift_en && w_fill_ok &&
                 ((w_hist_next & w_mask) == (pattern & w_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift_en) begin
            r_hist <= w_hist_next;
`ifdef SEQ_DETECT_NONOVERLAP_EN
            r_fill <= hit ? '0 : w_fill_next;
`else
            r_fill <= w_fill_next;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_detect_sched.sv
// =============================================================================
// Module   : seq_detect_sched
// Brief    : Config/arm/run/done controller with match counter around a
//            programmable serial pattern matcher. Option: SEQ_DETECT_NONOVERLAP_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_detect_sched
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = c_def_max_len,
    parameter int CNT_W   = c_def_cnt_w,
    localparam int LEN_W  = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             r_state;
    state_t             w_state_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_match;
    logic               r_err;

    logic w_cfg_acc;
    logic w_cfg_legal;
    logic w_cfg_store;
    logic w_run_start;
    logic w_core_clear;
    logic w_err;
    logic w_shift;
    logic w_hit;
    logic w_target_hit;

    assign cfg_ready = (r_state != ST_RUN);
    assign bit_ready = (r_state == ST_RUN) && !abort;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign err       = r_err;

    assign w_cfg_acc    = cfg_valid && cfg_ready;
    assign w_cfg_legal  = (cfg_len > LEN_W'(1)) && (cfg_len <= LEN_W'(MAX_LEN)) &&
                          (cfg_target != '0);
    assign w_shift      = bit_valid && bit_ready;
    assign w_target_hit = (({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, r_target});

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_shift),
        .clear    (w_core_clear),
        .bit_in   (bit_in),
        .pattern  (r_pattern),
        .len      (r_len),
        .hit      (w_hit)
    );

    always_comb begin
        w_state_next = r_state;
        w_cfg_store  = 1'b0;
        w_run_start  = 1'b0;
        w_core_clear = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_CONFIGURED;
                    w_core_clear = 1'b1;
                end else if (w_hit && w_target_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                // A config handshake always takes precedence over start.
                if (w_cfg_acc) begin
                    if (w_cfg_legal) begin
                        w_cfg_store  = 1'b1;
                        w_state_next = ST_CONFIGURED;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (start) begin
                    if (r_state == ST_IDLE) begin
                        w_err = 1'b1;
                    end else begin
                        w_run_start  = 1'b1;
                        w_core_clear = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_target  <= '0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_match <= w_hit;
            r_err   <= w_err;
            if (w_cfg_store) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_target  <= cfg_target;
            end
            if (w_run_start) begin
                r_cnt <= '0;
            end else if (w_hit && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
Controller and scheduler for a programmable serial pattern detector, generalising the fixed 11011 detectors in the sequential-logic library.
- Accepts a pattern configuration through a valid/ready handshake.
- Arms and runs detection over a handshaked serial bit stream, counting matches.
- Stops the stream and flags completion once a programmed match target is reached.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: width of match target and match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_pattern  in  MAX_LEN  pattern; LSB is the most recent bit.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_target  in  CNT_W  matches required before done.
- start  in  1  arm and run (level sampled per cycle).
- abort  in  1  stop run.
- bit_valid  in  1  serial bit offered.
- bit_in  in  1  serial bit.
- bit_ready  out  1  bit accepted when bit_valid && bit_ready.
- match  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  matches in current run.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.
- err  out  1  one-cycle illegal-request pulse.

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - pattern, len, target, history, fill and match_cnt cleared to 0.
  - match, err, busy and done are 0.
- States IDLE, CONFIGURED, RUN, DONE. All outputs are registered except cfg_ready and bit_ready, which decode combinationally from state.
- cfg_ready = 1 in IDLE, CONFIGURED and DONE; 0 in RUN.
- Config accept (cfg_valid && cfg_ready):
  - Legal if 1 < cfg_len <= MAX_LEN and cfg_target != 0.
  - Legal config is stored; next state is CONFIGURED; done clears.
  - Illegal config: err = 1 for one cycle; stored config and state are unchanged.
- start:
  - In CONFIGURED or DONE, with no config accept in the same cycle: next state RUN; history, fill and match_cnt cleared.
  - In IDLE: err pulse; state stays IDLE.
  - In RUN: ignored.
  - In the same cycle as a config accept: the config wins and start is ignored without err.
- bit_ready = (state==RUN) && !abort.
- Each accepted bit:
  - hist_next = {hist[MAX_LEN-2:0], bit_in}.
  - fill saturates at len.
  - hit = (fill >= len-1) && (hist_next[len-1:0] == pattern[len-1:0]).
- Match latency:
  - match is registered and high for exactly the cycle after the accepting edge.
  - match_cnt increments on the same edge.
  - If hit and match_cnt+1 == target, next state is DONE (bit_ready drops the following cycle).
  - match_cnt never wraps.
- Default is overlapping detection: history and fill are retained after a hit. For example, 11011011 with pattern 11011 hits at bits 5 and 8.
- abort in RUN:
  - next state CONFIGURED; fill and history cleared; match_cnt held.
  - abort wins over a simultaneous bit_valid, and the bit is not consumed.
  - abort outside RUN is ignored.
- DONE holds done = 1 and match_cnt until start (re-run with stored config) or a new config is accepted.
- Cycles with no bit_valid leave history untouched; no timeout.

Optional Feature:
- Macro SEQ_DETECT_NONOVERLAP_EN.
- Defined: on every hit, fill resets to 0, so the next match needs len fresh bits (non-overlapping detection).
- Undefined: overlapping behaviour as above.
- The port list is identical in both builds.

Decomposition:
- Package seq_det_pkg:
  - state enum (IDLE, CONFIGURED, RUN, DONE).
  - default MAX_LEN and CNT_W constants.
  - length-width localparam helper.
- Sub-module seq_match_core:
  - Contents: history shift register, fill counter, masked compare producing hit; the nonoverlap option lives here.
  - Inputs: shift enable, clear, bit, pattern, len.
- FSM, counter and handshakes remain in seq_detect_sched.

Test Plan:
- Overlap: cfg pattern=8'b00011011, len=5, target=2; start; stream 1,1,0,1,1,0,1,1 →
  - match pulses after bits 5 and 8;
  - match_cnt=2;
  - done=1;
  - bit_ready=0 from the cycle after the DONE transition.
- Nonoverlap build, same stimulus → a single match after bit 5; match_cnt=1; state remains RUN.
- Illegal config: len=0, or len=MAX_LEN+1, or target=0 → one-cycle err pulse; prior config and state unchanged; start behaves per prior config.
- start in IDLE → err pulse; busy stays 0. start with a simultaneous cfg_valid in CONFIGURED → config stored, no RUN, no err.
- abort asserted together with bit_valid after 3 bits of 11011 → bit not consumed; state CONFIGURED; match_cnt held. Re-start then a full 11011 → one match.
- Reset asserted mid-RUN between clock edges → outputs 0 and state IDLE immediately. After release, start gives err (config lost).
